// File: rtl/trace_mem_ctrl_pkg.sv
// Shared types and constants for the trace buffer memory controller.
package trace_mem_ctrl_pkg;

  localparam int unsigned TRB_DEPTH = 64;
  localparam int unsigned TRB_WIDTH = 16;

  typedef enum logic [1:0] {
    TrgTrace,
    TrgRwStream,
    TrgWStream,
    TrgRStream
  } trg_mode_t;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StPost,
    StDone
  } ctrl_state_t;

  function automatic logic is_stream(input trg_mode_t m);
    return (m != TrgTrace);
  endfunction

endpackage

// File: rtl/trace_mem_ctrl_ring_ptr.sv
// Ring pointer with one extra wrap bit so full and empty stay distinguishable.
module trace_mem_ctrl_ring_ptr #(
  parameter int unsigned AW = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [AW:0] ptr
);

  logic [AW:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/trace_mem_ctrl.sv
// Trace buffer sequencer: capture FSM, shared RAM port arbiter, post-trigger delay, readback.
// Optional overflow counter enabled by defining TRC_OVERFLOW_CNT_EN.
module trace_mem_ctrl
  import trace_mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = TRB_DEPTH,
  parameter int unsigned WIDTH = TRB_WIDTH,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned PW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  trg_mode_t        mode,
  input  logic             arm,
  input  logic [AW:0]      trg_delay,
  input  logic             store,
  input  logic [WIDTH-1:0] store_data,
  output logic             store_perm,
  input  logic             trg_event,
  input  logic [PW-1:0]    event_pos,
  input  logic             load_request,
  output logic             load_grant,
  output logic [WIDTH-1:0] load_data,
  output logic             trg_delayed,
  output logic [AW-1:0]    trg_addr,
  output logic [PW-1:0]    trg_pos,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
`ifdef TRC_OVERFLOW_CNT_EN
  ,
  output logic [15:0]      ovf_cnt
`endif
);

  ctrl_state_t      state_q;
  trg_mode_t        mode_q;
  logic [AW:0]      cnt_q;
  logic [AW-1:0]    trg_addr_q;
  logic [PW-1:0]    trg_pos_q;
  logic             load_pend_q;
  logic             rd_vld_q;
  logic [WIDTH-1:0] load_data_q;

  logic [AW:0]   wr_ptr, rd_ptr, fill;
  logic [AW-1:0] rd_addr;
  logic          stream, full, empty, acc, eligible, want, issue;

  trace_mem_ctrl_ring_ptr #(.AW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (arm),
    .inc   (acc),
    .ptr   (wr_ptr)
  );

  trace_mem_ctrl_ring_ptr #(.AW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (arm),
    .inc   (issue),
    .ptr   (rd_ptr)
  );

  assign stream = is_stream(mode_q);
  assign fill   = wr_ptr - rd_ptr;
  assign full   = (fill == (AW+1)'(DEPTH));
  assign empty  = (fill == '0);

  always_comb begin
    store_perm = 1'b0;
    case (state_q)
      StArmed: store_perm = stream ? !full : 1'b1;
      StPost:  store_perm = 1'b1;
      default: store_perm = 1'b0;
    endcase
  end

  // Trace readback walks DEPTH words starting at the oldest entry (wr_ptr); rd_ptr counts grants.
  assign eligible = stream ? (state_q == StArmed) && !empty
                           : (state_q == StDone) && !rd_ptr[AW];
  assign rd_addr  = stream ? rd_ptr[AW-1:0] : wr_ptr[AW-1:0] + rd_ptr[AW-1:0];

  assign acc   = store && store_perm;
  assign want  = load_request && !load_pend_q && !rd_vld_q && eligible;
  assign issue = (load_pend_q || want) && !acc && eligible && !arm;

  assign mem_en    = acc || issue;
  assign mem_we    = acc;
  assign mem_addr  = acc ? wr_ptr[AW-1:0] : (issue ? rd_addr : '0);
  assign mem_wdata = acc ? store_data : '0;

  assign load_grant  = rd_vld_q;
  assign load_data   = rd_vld_q ? mem_rdata : load_data_q;
  assign trg_delayed = stream ? (state_q == StArmed) && !empty : (state_q == StDone);
  assign trg_addr    = trg_addr_q;
  assign trg_pos     = trg_pos_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= TrgTrace;
      cnt_q       <= '0;
      trg_addr_q  <= '0;
      trg_pos_q   <= '0;
      load_pend_q <= 1'b0;
      rd_vld_q    <= 1'b0;
      load_data_q <= '0;
    end else begin
      rd_vld_q <= issue;
      if (rd_vld_q) begin
        load_data_q <= mem_rdata;
      end
      if (arm) begin
        if (state_q == StIdle) begin
          mode_q <= mode;
        end
        state_q     <= StArmed;
        cnt_q       <= '0;
        trg_addr_q  <= '0;
        trg_pos_q   <= '0;
        load_pend_q <= 1'b0;
      end else begin
        load_pend_q <= (load_pend_q || want) && !issue;
        case (state_q)
          StArmed: begin
            if (!stream && acc && trg_event) begin
              trg_addr_q <= wr_ptr[AW-1:0];
              trg_pos_q  <= event_pos;
              cnt_q      <= trg_delay;
              state_q    <= (trg_delay == '0) ? StDone : StPost;
            end
          end
          StPost: begin
            if (acc) begin
              cnt_q <= cnt_q - (AW+1)'(1);
              if (cnt_q == (AW+1)'(1)) begin
                state_q <= StDone;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TRC_OVERFLOW_CNT_EN
  logic [15:0] ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else if (arm) begin
      ovf_q <= '0;
    end else if (stream && (state_q == StArmed) && store && !store_perm &&
                 (ovf_q != 16'hFFFF)) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_q;
`endif

endmodule
